// File: rtl/note_display_scanner_pkg.sv
// note_display_scanner_pkg: shared constants, scan states and width helper for the note display scanner
package note_display_scanner_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h7;
  typedef enum logic {BLANK, DRIVE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/note_display_scanner_scan_timer.sv
// note_display_scanner_scan_timer: slot counter and BLANK/DRIVE sequencing; ports slot_index (current digit), drive_active (DRIVE phase), frame_boundary (this edge enters BLANK of digit 0)
module note_display_scanner_scan_timer
  import note_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IW           = cnt_w(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] slot_index,
  output logic          drive_active,
  output logic          frame_boundary
);
  localparam int CW = cnt_w(DIGIT_CYCLES);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end
  always_comb begin
    last           = (state == BLANK) ? (cnt == BLAST) : (cnt == DLAST);
    state_n        = last ? ((state == BLANK) ? DRIVE : BLANK) : state;
    cnt_n          = last ? '0 : cnt + 1'b1;
    idx_n          = (last && state == DRIVE) ? ((idx == ILAST) ? '0 : idx + 1'b1) : idx;
    frame_boundary = last && state == DRIVE && idx == ILAST;
  end
  assign slot_index   = idx;
  assign drive_active = state == DRIVE;
endmodule

// File: rtl/note_display_scanner.sv
// note_display_scanner: multiplexes one note decoder over NUM_DIGITS anodes; ports load/note_codes (tear-free code update), digit_enable (live), note_key/an (registered drive), load_ack/frame_start (pulses)
module note_display_scanner
  import note_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] note_codes,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  output logic [3:0]              note_key,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    load_ack,
  output logic                    frame_start
);
  localparam int IW = cnt_w(NUM_DIGITS);
  logic [IW-1:0] slot_index;
  logic drive_active, frame_boundary, on, fb_q, ack_q, pending;
  logic [NUM_DIGITS-1:0][3:0] active, shadow;
  logic [NUM_DIGITS-1:0] an_n;
  logic [3:0] key_n;
  note_display_scanner_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IW          (IW)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .slot_index    (slot_index),
    .drive_active  (drive_active),
    .frame_boundary(frame_boundary)
  );
  always_comb begin
    on    = drive_active && digit_enable[slot_index];
    an_n  = on ? ~(NUM_DIGITS'(1) << slot_index) : '1;
    key_n = on ? active[slot_index] : NOTE_OFF;
  end
  // Outputs trail the timer by one edge; the pulses are pipelined to stay aligned with an/note_key.
  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= '1;
      note_key    <= NOTE_OFF;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      fb_q        <= 1'b0;
      ack_q       <= 1'b0;
      active      <= {NUM_DIGITS{NOTE_OFF}};
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      an          <= an_n;
      note_key    <= key_n;
      fb_q        <= frame_boundary;
      frame_start <= fb_q;
      ack_q       <= frame_boundary & pending;
      load_ack    <= ack_q;
      shadow      <= load ? note_codes : shadow;
      // A load on the boundary edge re-arms pending so it lands at the next boundary.
      pending     <= load | (pending & ~frame_boundary);
      if (frame_boundary && pending) active <= shadow;
    end
  end
endmodule

// File: tb/tb_note_display_scanner.sv
module tb_note_display_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [15:0] note_codes = '0;
  logic [3:0] digit_enable = 4'hf;
  logic [3:0] note_key;
  logic [3:0] an;
  logic load_ack, frame_start;
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [3:0] m_act [4];
  logic [15:0] m_shadow;
  logic m_pend, m_ackf;
  logic [9:0] exp_v;
  note_display_scanner #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .note_codes(note_codes), .digit_enable(digit_enable),
    .note_key(note_key), .an(an), .load_ack(load_ack), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] got();
    return {an, note_key, load_ack, frame_start};
  endfunction
  // Drives one edge and predicts the outputs it produces. Frame position is simply k mod 32:
  // each 8-cycle slot is 2 blank cycles then 6 driven ones, and outputs trail by one edge.
  task automatic cyc(input logic r, input logic l, input logic [15:0] c, input logic [3:0] e);
    int p, d;
    logic dr;
    logic [3:0] ea, ek;
    reset = r; load = l; note_codes = c; digit_enable = e;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) m_act[i] = 4'h7;
      m_shadow = '0; m_pend = 1'b0; m_ackf = 1'b0; k = 0;
      exp_v = {4'hf, 4'h7, 1'b0, 1'b0};
    end else begin
      p = k % 32; d = (k % 32) / 8;
      dr = (p % 8) >= 2 && e[d];
      ea = dr ? ~(4'b0001 << d) : 4'hf;
      ek = dr ? m_act[d] : 4'h7;
      exp_v = {ea, ek, m_ackf, (p == 0 && k > 0)};
      m_ackf = (p == 31) && m_pend;
      if (p == 31 && m_pend) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_shadow[4*i +: 4];
        m_pend = 1'b0;
      end
      if (l) begin m_shadow = c; m_pend = 1'b1; end
      k++;
    end
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h0, 4'hf);
      checks++;
      if (got() !== exp_v || got() !== 10'b1111_0111_0_0) begin
        errors++; $display("FAIL reset got=%b exp=%b", got(), exp_v);
      end
    end
  endtask
  task automatic test_idle_scan();
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 4'hf);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL idle k=%0d got=%b exp=%b", k - 1, got(), exp_v); end
    end
  endtask
  task automatic test_load_enable();
    int acks = 0;
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 96; i++) begin
      cyc(1'b0, i == 5, 16'h9810, (i < 64) ? 4'hf : 4'b0101);
      acks += int'(load_ack);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL load_en k=%0d got=%b exp=%b", i, got(), exp_v); end
      if (i == 50) begin
        checks++;
        if (an !== 4'b1011 || note_key !== 4'h8) begin
          errors++; $display("FAIL load_digit2 an=%b key=%h want an=1011 key=8", an, note_key);
        end
      end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL load_ack_count got=%0d want=1", acks); end
  endtask
  task automatic test_back_to_back();
    int acks = 0;
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, i == 40 || i == 50, (i == 40) ? 16'h1111 : 16'h2222, 4'hf);
      acks += int'(load_ack);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL b2b k=%0d got=%b exp=%b", i, got(), exp_v); end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL b2b_ack_count got=%0d want=1", acks); end
  endtask
  task automatic test_reset_pending();
    int acks = 0;
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, i == 10, 16'h4321, 4'hf);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL rstpend_pre k=%0d got=%b exp=%b", i, got(), exp_v); end
    end
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    checks++;
    if (got() !== 10'b1111_0111_0_0) begin errors++; $display("FAIL rstpend_rst got=%b exp=1111011100", got()); end
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 4'hf);
      acks += int'(load_ack);
      checks++;
      if (got() !== exp_v || (an !== 4'hf && note_key !== 4'h7)) begin
        errors++; $display("FAIL rstpend_post k=%0d got=%b exp=%b", i, got(), exp_v);
      end
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL rstpend_ack got=%0d want=0", acks); end
  endtask
  task automatic test_boundary_load();
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, i == 31, 16'h0005, 4'hf);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL bnd k=%0d got=%b exp=%b", i, got(), exp_v); end
      if (i == 32 || i == 64) begin
        checks++;
        if (load_ack !== (i == 64)) begin errors++; $display("FAIL bnd_ack k=%0d got=%b want=%b", i, load_ack, i == 64); end
      end
      if (i == 66) begin
        checks++;
        if (note_key !== 4'h5 || an !== 4'b1110) begin
          errors++; $display("FAIL bnd_key got an=%b key=%h want an=1110 key=5", an, note_key);
        end
      end
    end
  endtask
  task automatic test_random();
    logic [3:0] en = 4'hf;
    cyc(1'b1, 1'b0, 16'h0, 4'hf);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) en = 4'($urandom);
      cyc(1'b0, $urandom_range(0, 15) == 0, 16'($urandom), en);
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL rand k=%0d got=%b exp=%b", i, got(), exp_v); end
    end
  endtask
  initial begin
    test_reset();
    test_idle_scan();
    test_load_enable();
    test_back_to_back();
    test_reset_pending();
    test_boundary_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
